// File: rtl/mccpu_pkg.sv
// Shared encodings for the mccpu multi-cycle control unit: FSM states,
// opcode/funct values, ALU operation codes and datapath select encodings.
package mccpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_EXECI  = 4'd4,
    S_IWB    = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_ERR    = 4'd15
  } state_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] GPR_RD  = 2'b00;
  localparam logic [1:0] GPR_RT  = 2'b01;
  localparam logic [1:0] GPR_R31 = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MDR = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] SRC_REG   = 2'b00;
  localparam logic [1:0] SRC_SHAMT = 2'b01;
  localparam logic [1:0] SRC_IMM   = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Shared instruction/data memory handshake between the control unit and memory.
interface mc_ctrl_if;
  logic mem_req;
  logic mem_ifetch;
  logic MemWrite;
  logic mem_ready;

  modport master (output mem_req, output mem_ifetch, output MemWrite, input mem_ready);
  modport slave  (input mem_req, input mem_ifetch, input MemWrite, output mem_ready);
endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct -> ALU operation decode; jr is not an ALU op and reads as illegal here.
module mc_alu_dec
  import mccpu_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       shift,
  output logic       illegal
);
  always_comb begin
    alu_op  = ALU_NOP;
    shift   = 1'b0;
    illegal = 1'b0;
    case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_SLT: alu_op = ALU_SLT;
      FN_SLL: begin alu_op = ALU_SLL; shift = 1'b1; end
      FN_SRL: begin alu_op = ALU_SRL; shift = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for mccpu: sequences FETCH/DECODE/EXEC/MEM/WB and
// guards every memory access with a bounded wait that faults into ERR.
module mc_ctrl
  import mccpu_pkg::*;
#(
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 16,   // 1..255, must fit below 2**CNT_W
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  mc_ctrl_if.master          mem,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         ALUSrc,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [3:0]         state,
  output logic               err
);

  state_t           state_q, nxt;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
  alu_op_t          dec_op;
  logic             dec_shift, dec_illegal;
  logic             mem_st, timeout;

  mc_alu_dec u_alu_dec (
    .funct   (Funct),
    .alu_op  (dec_op),
    .shift   (dec_shift),
    .illegal (dec_illegal)
  );

  assign mem_st  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Fault on the last permitted wait cycle; a ready in that same cycle still completes.
  assign timeout = mem_st && !mem.mem_ready && (cnt == CNT_W'(WAIT_MAX - 1));

  always_comb begin
    nxt = state_q;
    case (state_q)
      S_FETCH:  if (mem.mem_ready) nxt = S_DECODE;
      S_DECODE:
        case (Op)
          OP_RTYPE:        nxt = (Funct == FN_JR) ? S_JR : (dec_illegal ? S_ERR : S_EXEC);
          OP_ADDI, OP_ORI: nxt = S_EXECI;
          OP_LW, OP_SW:    nxt = S_MEMADR;
          OP_BEQ, OP_BNE:  nxt = S_BRANCH;
          OP_J:            nxt = S_JUMP;
          OP_JAL:          nxt = S_JAL;
          default:         nxt = S_ERR;
        endcase
      S_EXEC:   nxt = S_ALUWB;
      S_EXECI:  nxt = S_IWB;
      S_MEMADR: nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem.mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem.mem_ready) nxt = S_FETCH;
      S_ALUWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP, S_JAL, S_JR: nxt = S_FETCH;
      S_ERR:    nxt = S_ERR;
      default:  nxt = S_ERR;
    endcase
    if (timeout) nxt = S_ERR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= nxt;
      err_q   <= err_q | (nxt == S_ERR);
      // Held at zero outside memory states, so each access starts from a clean count.
      if (mem_st && !mem.mem_ready) cnt <= cnt + CNT_W'(1);
      else                          cnt <= '0;
    end
  end

  logic       req, ifetch, mwr, pcw, irw, rw;
  logic [1:0] ext, npc, asrc, gsel, wd;
  alu_op_t    alu;

  // Outputs decode from the state register; rst gates them so strobes drop without a clock.
  always_comb begin
    req = 1'b0; ifetch = 1'b0; mwr = 1'b0; pcw = 1'b0; irw = 1'b0; rw = 1'b0;
    ext = EXT_ZERO; npc = NPC_PC4; asrc = SRC_REG; gsel = GPR_RD; wd = WD_ALU;
    alu = ALU_NOP;
    if (rst) begin
      case (state_q)
        S_FETCH:  begin req = 1'b1; ifetch = 1'b1; irw = mem.mem_ready; pcw = mem.mem_ready; end
        S_EXEC:   begin alu = dec_op; asrc = dec_shift ? SRC_SHAMT : SRC_REG; end
        S_ALUWB:  begin rw = 1'b1; gsel = GPR_RD; wd = WD_ALU; end
        S_EXECI:  begin
          asrc = SRC_IMM;
          ext  = (Op == OP_ORI) ? EXT_ZERO : EXT_SIGN;
          alu  = (Op == OP_ORI) ? ALU_OR : ALU_ADD;
        end
        S_IWB:    begin rw = 1'b1; gsel = GPR_RT; wd = WD_ALU; end
        S_MEMADR: begin asrc = SRC_IMM; ext = EXT_SIGN; alu = ALU_ADD; end
        S_MEMRD:  req = 1'b1;
        S_MEMWB:  begin rw = 1'b1; gsel = GPR_RT; wd = WD_MDR; end
        S_MEMWR:  begin req = 1'b1; mwr = 1'b1; end
        S_BRANCH: begin
          alu = ALU_SUB; ext = EXT_SIGN; npc = NPC_BR;
          pcw = (Op == OP_BNE) ? !Zero : Zero;
        end
        S_JUMP:   begin pcw = 1'b1; npc = NPC_J; end
        S_JAL:    begin pcw = 1'b1; npc = NPC_J; rw = 1'b1; gsel = GPR_R31; wd = WD_PC; end
        S_JR:     begin pcw = 1'b1; npc = NPC_JR; end
        default:  ;
      endcase
    end
  end

  assign mem.mem_req    = req;
  assign mem.mem_ifetch = ifetch;
  assign mem.MemWrite   = mwr;
  assign PCWrite        = pcw;
  assign IRWrite        = irw;
  assign RegWrite       = rw;
  assign EXTOp          = ext;
  assign ALUOp          = ALUOP_W'(alu);
  assign NPCOp          = npc;
  assign ALUSrc         = asrc;
  assign GPRSel         = gsel;
  assign WDSel          = wd;
  assign state          = state_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: instruction sequences with hand-computed
// per-cycle expectations, memory timeout, illegal decode and async reset abort.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Op = '0, Funct = '0;
  logic       Zero = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, err;
  logic [1:0] EXTOp, NPCOp, ALUSrc, GPRSel, WDSel;
  logic [3:0] ALUOp, state;
  int         n_chk = 0, n_err = 0;

  mc_ctrl_if mem();

  mc_ctrl #(.ALUOP_W(4), .WAIT_MAX(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mem(mem), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrc(ALUSrc), .GPRSel(GPRSel),
    .WDSel(WDSel), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic z);
    mem.mem_ready = rdy;
    Zero          = z;
    #1;
  endtask

  // One clock: inputs change just after the edge, checks run 2 time units after it.
  task automatic cyc(input logic rdy, input logic z);
    @(posedge clk);
    #1;
    drive(rdy, z);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem.mem_ready = 1'b0;
    Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    mem.mem_ready = 1'b1;
    #3;
    chk("rst_state",  32'(state), 0);
    chk("rst_req",    32'(mem.mem_req), 0);
    chk("rst_irw",    32'(IRWrite), 0);
    chk("rst_pcw",    32'(PCWrite), 0);
    chk("rst_err",    32'(err), 0);
    chk("rst_ifetch", 32'(mem.mem_ifetch), 0);
    do_reset();

    // add $8,$9,$10
    Op = 6'h00; Funct = 6'h20;
    drive(1, 0);
    chk("add_f_state", 32'(state), 0);
    chk("add_f_req",   32'(mem.mem_req), 1);
    chk("add_f_ifet",  32'(mem.mem_ifetch), 1);
    chk("add_f_irw",   32'(IRWrite), 1);
    chk("add_f_pcw",   32'(PCWrite), 1);
    cyc(0, 0); chk("add_d_state", 32'(state), 1); chk("add_d_req", 32'(mem.mem_req), 0);
    cyc(0, 0); chk("add_e_state", 32'(state), 2); chk("add_e_alu", 32'(ALUOp), 1);
    chk("add_e_src", 32'(ALUSrc), 0); chk("add_e_rw", 32'(RegWrite), 0);
    cyc(0, 0); chk("add_wb_state", 32'(state), 3); chk("add_wb_rw", 32'(RegWrite), 1);
    chk("add_wb_gsel", 32'(GPRSel), 0); chk("add_wb_wd", 32'(WDSel), 0);

    // sll
    Funct = 6'h00;
    cyc(1, 0); chk("sll_f_state", 32'(state), 0);
    cyc(0, 0); chk("sll_d_state", 32'(state), 1);
    cyc(0, 0); chk("sll_e_state", 32'(state), 2); chk("sll_e_alu", 32'(ALUOp), 6);
    chk("sll_e_src", 32'(ALUSrc), 1);
    cyc(0, 0); chk("sll_wb_state", 32'(state), 3);

    // ori
    Op = 6'h0D;
    cyc(1, 0); chk("ori_f_state", 32'(state), 0);
    cyc(0, 0); chk("ori_d_state", 32'(state), 1);
    cyc(0, 0); chk("ori_ei_state", 32'(state), 4); chk("ori_ei_src", 32'(ALUSrc), 2);
    chk("ori_ei_ext", 32'(EXTOp), 0); chk("ori_ei_alu", 32'(ALUOp), 4);
    cyc(0, 0); chk("ori_wb_state", 32'(state), 5); chk("ori_wb_rw", 32'(RegWrite), 1);
    chk("ori_wb_gsel", 32'(GPRSel), 1);

    // lw $8,4($9) with three stall cycles in MEMRD
    Op = 6'h23;
    cyc(1, 0); chk("lw_f_state", 32'(state), 0);
    cyc(0, 0); chk("lw_d_state", 32'(state), 1);
    cyc(0, 0); chk("lw_ma_state", 32'(state), 6); chk("lw_ma_src", 32'(ALUSrc), 2);
    chk("lw_ma_ext", 32'(EXTOp), 1); chk("lw_ma_alu", 32'(ALUOp), 1);
    for (int i = 0; i < 4; i++) begin
      cyc((i == 3) ? 1'b1 : 1'b0, 0);
      chk("lw_mr_state", 32'(state), 7);
      chk("lw_mr_req",   32'(mem.mem_req), 1);
      chk("lw_mr_ifet",  32'(mem.mem_ifetch), 0);
    end
    cyc(0, 0); chk("lw_wb_state", 32'(state), 8); chk("lw_wb_rw", 32'(RegWrite), 1);
    chk("lw_wb_wd", 32'(WDSel), 1); chk("lw_wb_gsel", 32'(GPRSel), 1);

    // beq taken, beq not taken, bne taken
    Op = 6'h04;
    cyc(1, 0); chk("lw_done_state", 32'(state), 0);
    cyc(0, 0); chk("beq1_d_state", 32'(state), 1);
    cyc(0, 1); chk("beq1_state", 32'(state), 10); chk("beq1_pcw", 32'(PCWrite), 1);
    chk("beq1_npc", 32'(NPCOp), 1); chk("beq1_alu", 32'(ALUOp), 2); chk("beq1_ext", 32'(EXTOp), 1);
    cyc(1, 0); chk("beq2_f_state", 32'(state), 0);
    cyc(0, 0); chk("beq2_d_state", 32'(state), 1);
    cyc(0, 0); chk("beq2_state", 32'(state), 10); chk("beq2_pcw", 32'(PCWrite), 0);
    chk("beq2_npc", 32'(NPCOp), 1);
    Op = 6'h05;
    cyc(1, 0); chk("bne_f_state", 32'(state), 0);
    cyc(0, 0); chk("bne_d_state", 32'(state), 1);
    cyc(0, 0); chk("bne_state", 32'(state), 10); chk("bne_pcw", 32'(PCWrite), 1);

    // jal
    Op = 6'h03;
    cyc(1, 0); chk("jal_f_state", 32'(state), 0);
    cyc(0, 0); chk("jal_d_state", 32'(state), 1);
    cyc(0, 0); chk("jal_state", 32'(state), 12); chk("jal_pcw", 32'(PCWrite), 1);
    chk("jal_rw", 32'(RegWrite), 1); chk("jal_gsel", 32'(GPRSel), 2);
    chk("jal_wd", 32'(WDSel), 2); chk("jal_npc", 32'(NPCOp), 2);

    // jr
    Op = 6'h00; Funct = 6'h08;
    cyc(1, 0); chk("jr_f_state", 32'(state), 0);
    cyc(0, 0); chk("jr_d_state", 32'(state), 1);
    cyc(0, 0); chk("jr_state", 32'(state), 13); chk("jr_npc", 32'(NPCOp), 3);
    chk("jr_pcw", 32'(PCWrite), 1);

    // sw completing on first request cycle
    Op = 6'h2B;
    cyc(1, 0); chk("sw_f_state", 32'(state), 0);
    cyc(0, 0); chk("sw_d_state", 32'(state), 1);
    cyc(0, 0); chk("sw_ma_state", 32'(state), 6);
    cyc(1, 0); chk("sw_mw_state", 32'(state), 9); chk("sw_mw_mwr", 32'(mem.MemWrite), 1);
    chk("sw_mw_req", 32'(mem.mem_req), 1);
    cyc(1, 0); chk("sw_done_state", 32'(state), 0);

    // sw aborted by reset during a MEMWR stall
    cyc(0, 0); chk("swr_d_state", 32'(state), 1);
    cyc(0, 0); chk("swr_ma_state", 32'(state), 6);
    cyc(0, 0); chk("swr_mw_state", 32'(state), 9);
    cyc(0, 0); chk("swr_mw_mwr", 32'(mem.MemWrite), 1);
    #2 rst = 1'b0;
    #1;
    chk("swr_rst_mwr",   32'(mem.MemWrite), 0);
    chk("swr_rst_req",   32'(mem.mem_req), 0);
    chk("swr_rst_state", 32'(state), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 0);
    chk("swr_rel_state", 32'(state), 0);
    chk("swr_rel_err",   32'(err), 0);
    chk("swr_rel_req",   32'(mem.mem_req), 1);

    // FETCH timeout: ready never comes, ERR on the 9th cycle
    for (int i = 2; i <= 8; i++) cyc(0, 0);
    chk("to_c8_state", 32'(state), 0);
    chk("to_c8_req",   32'(mem.mem_req), 1);
    cyc(0, 0);
    chk("to_c9_state", 32'(state), 15);
    chk("to_c9_err",   32'(err), 1);
    chk("to_c9_req",   32'(mem.mem_req), 0);
    cyc(1, 0);
    chk("to_stick_state", 32'(state), 15);
    chk("to_stick_irw",   32'(IRWrite), 0);

    // ready on the last permitted cycle wins; then illegal Op 0x3F faults
    do_reset();
    drive(0, 0);
    for (int i = 2; i <= 7; i++) cyc(0, 0);
    Op = 6'h3F;
    cyc(1, 0); chk("edge_c8_irw", 32'(IRWrite), 1);
    cyc(0, 0); chk("edge_c9_state", 32'(state), 1); chk("edge_c9_err", 32'(err), 0);
    cyc(0, 0); chk("ill_op_state", 32'(state), 15); chk("ill_op_err", 32'(err), 1);

    // illegal R-type funct
    do_reset();
    Op = 6'h00; Funct = 6'h3F;
    drive(1, 0); chk("ill_fn_rst_err", 32'(err), 0);
    cyc(0, 0); chk("ill_fn_d_state", 32'(state), 1);
    cyc(0, 0); chk("ill_fn_state", 32'(state), 15); chk("ill_fn_err", 32'(err), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit, successor to the single-cycle decoder, for the next-generation mccpu core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Talks to one shared instruction/data memory through a req/ready handshake with a bounded wait.
- Drives the same datapath selects as before (EXTOp, ALUOp, NPCOp, ALUSrc, GPRSel, WDSel), plus PCWrite, IRWrite, mem_req, err.

Parameters:
- ALUOP_W, 4: width of ALUOp.
- WAIT_MAX, 16: maximum cycles mem_req may stay high without mem_ready before fault. Range 1..255.
- CNT_W, 8: width of the wait counter. Must satisfy 2**CNT_W > WAIT_MAX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Op  in  6  instruction opcode from IR.
- Funct  in  6  R-type funct from IR.
- Zero  in  1  ALU zero flag (combinational, current cycle).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_ifetch  out  1  request is an instruction fetch (address = PC); 0 means address = ALU result register.
- MemWrite  out  1  write strobe, qualified by mem_req.
- PCWrite  out  1  load NPC into PC.
- IRWrite  out  1  load readdata into IR.
- RegWrite  out  1  register-file write.
- EXTOp  out  2  00 zero-extend, 01 sign-extend.
- ALUOp  out  ALUOP_W  operation code from pkg.
- NPCOp  out  2  00 PC+4, 01 branch, 10 jump, 11 jr.
- ALUSrc  out  2  bit0: A = shamt; bit1: B = Imm32.
- GPRSel  out  2  00 rd, 01 rt, 10 r31.
- WDSel  out  2  00 ALUOut, 01 MDR, 10 PC (already incremented).
- state  out  4  current state, for debug.
- err  out  1  sticky fault (illegal opcode/funct or memory timeout).

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, wait counter=0, err=0. All strobes (mem_req, MemWrite, PCWrite, IRWrite, RegWrite) are 0 while rst=0. All selects are 0.
- Strobes are Moore outputs, except PCWrite in FETCH/BRANCH and IRWrite in FETCH, which are gated combinationally by mem_ready/Zero.
- FETCH: mem_req=1, mem_ifetch=1. On mem_ready: IRWrite=1, PCWrite=1, NPCOp=00, then go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle), branching on Op/Funct:
  - R-type (add, sub, and, or, slt, sll, srl) -> EXEC.
  - jr (R-type, funct 001000) -> JR.
  - addi, ori -> EXECI.
  - lw, sw -> MEMADR.
  - beq, bne -> BRANCH.
  - j -> JUMP.
  - jal -> JAL.
  - Any other Op/Funct -> ERR.
- EXEC: ALUOp from funct; ALUSrc=01 for sll/srl, else 00. Next ALUWB.
- ALUWB: RegWrite=1, GPRSel=00, WDSel=00. Next FETCH.
- EXECI: ALUSrc=10. addi uses EXTOp=01, ALU_ADD; ori uses EXTOp=00, ALU_OR. Next IWB.
- IWB: RegWrite=1, GPRSel=01, WDSel=00. Next FETCH.
- MEMADR: ALUSrc=10, EXTOp=01, ALU_ADD. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, mem_ifetch=0. Stay until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, GPRSel=01, WDSel=01. Next FETCH.
- MEMWR: mem_req=1, MemWrite=1. Stay until mem_ready, then FETCH.
- BRANCH: ALU_SUB, EXTOp=01, NPCOp=01. PCWrite = Zero for beq, !Zero for bne. Next FETCH.
- JUMP: PCWrite=1, NPCOp=10. Next FETCH.
- JAL: PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10. Next FETCH.
- JR: PCWrite=1, NPCOp=11. Next FETCH.
- Wait counter:
  - Clears on entry to any memory state and on mem_ready.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - When the counter reaches WAIT_MAX with no ready: go to ERR; no strobes are issued that cycle.
  - mem_ready in the same cycle the counter reaches WAIT_MAX wins (normal completion).
- ERR: err=1, all strobes 0. Absorbing until reset.
- Latency with mem_ready in the first request cycle:
  - R-type, addi/ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j, jal, jr: 3 cycles.
  - Each memory stall adds 1 cycle.
- Reset asserted mid-operation aborts the access immediately. mem_req/MemWrite drop asynchronously.

Decomposition:
- mccpu_pkg holds:
  - state encodings: FETCH=0, DECODE=1, EXEC=2, ALUWB=3, EXECI=4, IWB=5, MEMADR=6, MEMRD=7, MEMWB=8, MEMWR=9, BRANCH=10, JUMP=11, JAL=12, JR=13, ERR=15.
  - opcode/funct constants.
  - ALUOp codes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, SLL=6, SRL=7.
  - NPCOp/WDSel/GPRSel encodings.
- One sub-module, mc_alu_dec: combinational funct->ALUOp decode with an illegal flag.

Test Plan:
- add $8,$9,$10 (0x012A4020), mem_ready=1 in FETCH -> states 0,1,2,3. ALUOp=1 in EXEC. RegWrite=1, GPRSel=00 in cycle 4. Back to FETCH in cycle 5.
- lw $8,4($9) (0x8D280004), mem_ready delayed 3 cycles in MEMRD -> mem_req high 4 cycles in state 7, then MEMWB with RegWrite=1, WDSel=01. Total 8 cycles.
- beq with Zero=1, then Zero=0 -> BRANCH PCWrite=1 then 0, NPCOp=01 both times. bne (Op 000101) with Zero=0 -> PCWrite=1.
- jal 0x0C000010 -> JAL state: PCWrite=1, RegWrite=1, GPRSel=10, WDSel=10. Total 3 cycles.
- WAIT_MAX=8, mem_ready held 0 in FETCH -> state=15, err=1 on the 9th cycle. Only rst clears it. Illegal Op 0x3F also -> ERR after DECODE.
- sw with rst dropped during MEMWR stall -> MemWrite/mem_req go 0 without a clock edge. After release, state=0 and err=0.
